// File: rtl/clock_gating_controller.sv
// ----------------------------------------------------------------------------
// clock_gating_controller
//
// Drives the enable input of a clock_gater cell. Runs on the free-running
// clock and watches an activity flag from the gated domain. After IDLE_CYCLES
// consecutive idle samples the gate is closed. An explicit wake (wake_request
// or disable_gating) reopens it, and ready follows WAKE_CYCLES edges later
// once the gated clock has settled.
//
// Parameters:
//   IDLE_CYCLES    consecutive idle samples before gating (>= 1)
//   WAKE_CYCLES    edges from reopening the gate to asserting ready (>= 1)
//
// Ports:
//   clock           free-running clock (same as the gater's clock_in)
//   reset           asynchronous, active-high reset
//   busy            1 = gated domain has work in progress
//   wake_request    level request to have the gated clock running
//   disable_gating  1 = never gate; while gated, behaves as a wake request
//   enable          registered gate enable, 1 = clock passes
//   ready           registered, 1 = gated clock running and settled
//   gated           registered status, 1 = gate closed
// ----------------------------------------------------------------------------
module clock_gating_controller #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic busy,
    input  logic wake_request,
    input  logic disable_gating,
    output logic enable,
    output logic ready,
    output logic gated
);

    localparam int MAX_CYCLES    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int COUNTER_WIDTH = $clog2(MAX_CYCLES + 1);

    localparam logic [COUNTER_WIDTH-1:0] IDLE_LAST = COUNTER_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] WAKE_LAST = COUNTER_WIDTH'(WAKE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        RUNNING    = 2'd0,
        IDLE_COUNT = 2'd1,
        GATED      = 2'd2,
        WAKING     = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] count_next;
    logic                     idle;

    assign idle = !busy && !wake_request && !disable_gating;

    // ------------------------------------------------------------------------
    // Next-state and shared counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        count_next = count;

        case (state)
            RUNNING: begin
                if (idle) begin
                    // With a single-cycle threshold the first idle sample is
                    // already the terminal one, so IDLE_COUNT is skipped.
                    state_next = (IDLE_CYCLES == 1) ? GATED : IDLE_COUNT;
                    count_next = COUNT_ONE;
                end else begin
                    count_next = '0;
                end
            end

            IDLE_COUNT: begin
                if (!idle) begin
                    // Any activity, including on the terminal sample, wins.
                    state_next = RUNNING;
                    count_next = '0;
                end else if (count == IDLE_LAST) begin
                    state_next = GATED;
                end else if (count != COUNT_MAX) begin
                    count_next = count + COUNT_ONE;
                end
            end

            GATED: begin
                // busy is not looked at: the gated domain is frozen and its
                // activity flag cannot change meaningfully.
                if (wake_request || disable_gating) begin
                    state_next = WAKING;
                    count_next = '0;
                end
            end

            WAKING: begin
                // Wake requests are already being served; only the settle
                // count matters here.
                if (count == WAKE_LAST) begin
                    state_next = RUNNING;
                    count_next = '0;
                end else if (count != COUNT_MAX) begin
                    count_next = count + COUNT_ONE;
                end
            end

            default: begin
                state_next = RUNNING;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state itself and
    // never depend combinationally on an input.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state  <= RUNNING;
            count  <= '0;
            enable <= 1'b1;
            ready  <= 1'b1;
            gated  <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            enable <= (state_next != GATED);
            ready  <= (state_next == RUNNING) || (state_next == IDLE_COUNT);
            gated  <= (state_next == GATED);
        end
    end

endmodule

// File: tb/tb_clock_gating_controller.sv
// ----------------------------------------------------------------------------
// tb_clock_gating_controller
//
// Directed bench for clock_gating_controller. The main instance uses
// IDLE_CYCLES=4, WAKE_CYCLES=2; a second instance uses IDLE_CYCLES=1,
// WAKE_CYCLES=1. A behavioural low-phase latch gater produces clock_out so
// that gated-clock edges can be counted.
// Outputs are compared 1 time unit after the rising edge; inputs are changed
// at the same point, so they are sampled at the following edge.
// Status vectors are {enable, ready, gated}.
// ----------------------------------------------------------------------------
module tb_clock_gating_controller;

    logic clock;
    logic reset;
    logic busy;
    logic wake_request;
    logic disable_gating;
    logic enable;
    logic ready;
    logic gated;

    logic busy1;
    logic wake_request1;
    logic disable_gating1;
    logic enable1;
    logic ready1;
    logic gated1;

    logic en_latch;
    logic clock_out;
    int   out_edges = 0;
    int   edge_mark;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_RUN   = 3'b110;
    localparam logic [2:0] S_GATED = 3'b001;
    localparam logic [2:0] S_WAKE  = 3'b100;

    clock_gating_controller #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .busy           (busy),
        .wake_request   (wake_request),
        .disable_gating (disable_gating),
        .enable         (enable),
        .ready          (ready),
        .gated          (gated)
    );

    clock_gating_controller #(
        .IDLE_CYCLES(1),
        .WAKE_CYCLES(1)
    ) dut1 (
        .clock          (clock),
        .reset          (reset),
        .busy           (busy1),
        .wake_request   (wake_request1),
        .disable_gating (disable_gating1),
        .enable         (enable1),
        .ready          (ready1),
        .gated          (gated1)
    );

    // Behavioural clock gater: transparent latch while the clock is low.
    always_latch begin
        if (!clock) en_latch = enable;
    end
    assign clock_out = clock & en_latch;

    always @(posedge clock_out) out_edges = out_edges + 1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] st();
        return {29'd0, enable, ready, gated};
    endfunction

    function automatic logic [31:0] st1();
        return {29'd0, enable1, ready1, gated1};
    endfunction

    initial begin
        reset           = 1'b1;
        busy            = 1'b1;
        wake_request    = 1'b0;
        disable_gating  = 1'b0;
        busy1           = 1'b1;
        wake_request1   = 1'b0;
        disable_gating1 = 1'b0;

        // ---------------- Reset ----------------
        #1;
        check("reset_async", st(), S_RUN);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", st(), S_RUN);
        end
        reset = 1'b0;
        step();
        check("after_reset", st(), S_RUN);
        edge_mark = out_edges;
        for (int i = 0; i < 10; i++) step();
        check("clk_out_full_rate", out_edges - edge_mark, 10);

        // ---------------- Idle gating ----------------
        busy = 1'b0;
        step();
        check("idle_edge0", st(), S_RUN);
        step();
        check("idle_edge1", st(), S_RUN);
        step();
        check("idle_edge2", st(), S_RUN);
        step();
        check("idle_edge3_gated", st(), S_GATED);
        check("clk_out_high_through_edge3", {31'd0, clock_out}, 1);
        edge_mark = out_edges;
        for (int i = 0; i < 5; i++) step();
        check("clk_out_stopped", out_edges - edge_mark, 0);

        // busy toggling while gated must not wake
        busy = 1'b1;
        step();
        check("gated_busy_hi", st(), S_GATED);
        busy = 1'b0;
        step();
        check("gated_busy_lo", st(), S_GATED);
        busy = 1'b1;
        step();
        check("gated_busy_hi2", st(), S_GATED);

        // ---------------- Wake (1-cycle pulse) ----------------
        wake_request = 1'b1;
        step();
        check("wake_k", st(), S_WAKE);
        wake_request = 1'b0;
        step();
        check("wake_k1", st(), S_WAKE);
        step();
        check("wake_k2_ready", st(), S_RUN);
        edge_mark = out_edges;
        for (int i = 0; i < 5; i++) step();
        check("clk_out_resumed", out_edges - edge_mark, 5);
        check("running_after_wake", st(), S_RUN);

        // ---------------- Idle abort on the terminal sample ----------------
        busy = 1'b0;
        step();
        check("abort_a0", st(), S_RUN);
        step();
        check("abort_a1", st(), S_RUN);
        step();
        check("abort_a2", st(), S_RUN);
        busy = 1'b1;
        step();
        check("abort_a3_busy_wins", st(), S_RUN);
        busy = 1'b0;
        step();
        check("abort_b0", st(), S_RUN);
        step();
        check("abort_b1", st(), S_RUN);
        step();
        check("abort_b2", st(), S_RUN);
        step();
        check("abort_b3_gated", st(), S_GATED);

        // ---------------- disable_gating as wake ----------------
        disable_gating = 1'b1;
        step();
        check("dis_wake_k", st(), S_WAKE);
        step();
        check("dis_wake_k1", st(), S_WAKE);
        step();
        check("dis_wake_k2_ready", st(), S_RUN);

        // ---------------- disable_gating held for 50 idle cycles ----------------
        for (int i = 0; i < 50; i++) begin
            step();
            check("dis_never_gate", st(), S_RUN);
        end

        // ---------------- simultaneous wake + disable in GATED ----------------
        disable_gating = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("regate_edge2", st(), S_RUN);
        step();
        check("regate_edge3", st(), S_GATED);
        wake_request   = 1'b1;
        disable_gating = 1'b1;
        step();
        check("both_wake_k", st(), S_WAKE);
        wake_request   = 1'b0;
        disable_gating = 1'b0;
        busy           = 1'b1;
        step();
        check("both_wake_k1", st(), S_WAKE);
        step();
        check("both_wake_k2", st(), S_RUN);

        // ---------------- Reset mid-WAKING ----------------
        busy = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("gate_before_midreset", st(), S_GATED);
        wake_request = 1'b1;
        step();
        check("midreset_waking", st(), S_WAKE);
        wake_request = 1'b0;
        busy         = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_async", st(), S_RUN);
        step();
        reset = 1'b0;
        step();
        check("midreset_released", st(), S_RUN);

        // ---------------- IDLE_CYCLES=1, WAKE_CYCLES=1 instance ----------------
        check("i1_running", st1(), S_RUN);
        busy1 = 1'b0;
        step();
        check("i1_first_idle_gates", st1(), S_GATED);
        wake_request1 = 1'b1;
        step();
        check("i1_wake", st1(), S_WAKE);
        wake_request1 = 1'b0;
        busy1         = 1'b1;
        step();
        check("i1_ready", st1(), S_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
